serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 106 ++++++++++
 tb/tb_serial_subtractor.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b one bit per cycle, LSB first,
// and publishes diff plus borrow/overflow/zero flags with a one-cycle done pulse.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q, b_q, sh_q;
    logic             a_msb_q, b_msb_q;
    logic             br_q;

    logic             d_bit, br_next, last_bit;
    logic [WIDTH-1:0] sh_next;

    // Operand registers shift right so bit 0 is always the bit being processed;
    // the original sign bits are kept aside for the overflow flag.
    assign d_bit    = a_q[0] ^ b_q[0] ^ br_q;
    assign br_next  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    assign sh_next  = {d_bit, sh_q[WIDTH-1:1]};
    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    // NOTE: every signal written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_bit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            sh_q    <= '0;
            br_q    <= 1'b0;
            diff    <= '0;
            borrow  <= 1'b0;
            ovf     <= 1'b0;
            zero    <= 1'b0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        a_msb_q <= a[WIDTH-1];
                        b_msb_q <= b[WIDTH-1];
                        cnt_q   <= '0;
                        sh_q    <= '0;
                        br_q    <= 1'b0;
                    end
                end
                RUN: begin
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    sh_q  <= sh_next;
                    br_q  <= br_next;
                    cnt_q <= cnt_q + 1'b1;
                    if (last_bit) begin
                        diff   <= sh_next;
                        borrow <= br_next;
                        ovf    <= (a_msb_q != b_msb_q) && (sh_next[WIDTH-1] != a_msb_q);
                        zero   <= (sh_next == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: expected results are queued when an
// operation is launched and compared when done pulses.
module tb_serial_subtractor;

    localparam int W      = 8;
    localparam int BUDGET = 2 * W + 4;

    typedef struct packed {
        logic [W-1:0] diff;
        logic         borrow;
        logic         ovf;
        logic         zero;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a, b;
    logic [W-1:0] diff;
    logic         borrow, ovf, zero, busy, done;

    int           total = 0;
    int           bad   = 0;
    exp_t         sb[$];
    logic [W-1:0] last_diff;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .diff   (diff),
        .borrow (borrow),
        .ovf    (ovf),
        .zero   (zero),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv);
        exp_t e;
        int   sa, sbv, sd;
        sa       = int'($signed(av));
        sbv      = int'($signed(bv));
        sd       = sa - sbv;
        e.diff   = av - bv;
        e.borrow = (av < bv);
        e.ovf    = (sd > (2 ** (W - 1)) - 1) || (sd < -(2 ** (W - 1)));
        e.zero   = (e.diff == '0);
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_result();
        exp_t e;
        e = sb.pop_front();
        check("diff", diff, e.diff);
        check("borrow", borrow, e.borrow);
        check("ovf", ovf, e.ovf);
        check("zero", zero, e.zero);
        last_diff = e.diff;
    endtask

    // Called on a falling edge; returns on the falling edge of the first IDLE
    // cycle after DONE, so back-to-back calls exercise the fastest restart.
    task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv);
        int lat;
        bit seen;
        start = 1'b1;
        a     = av;
        b     = bv;
        sb.push_back(model(av, bv));
        @(negedge clk);
        start = 1'b0;
        a     = ~av;
        b     = ~bv;
        check("busy_run", busy, 1);
        check("hold_diff", diff, last_diff);
        lat  = 1;
        seen = 0;
        while (!seen && lat < BUDGET) begin
            if (done === 1'b1) seen = 1;
            else begin
                @(negedge clk);
                lat++;
                if (lat <= W) check("busy_run_mid", busy, 1);
            end
        end
        check("done_latency", lat, W + 1);
        if (seen) compare_result();
        @(negedge clk);
        check("done_end", done, 0);
        check("busy_idle", busy, 0);
    endtask

    initial begin
        logic [W-1:0] av, bv;
        logic         exp_done;
        int           n_done;

        rst       = 1'b0;
        start     = 1'b0;
        a         = '0;
        b         = '0;
        last_diff = '0;
        #1 rst = 1'b1;
        #1;
        check("rst_diff", diff, 0);
        check("rst_flags", {borrow, ovf, zero, busy, done}, 0);

        @(negedge clk);
        rst = 1'b0;

        do_op(8'd200, 8'd50);
        do_op(8'd50, 8'd200);
        do_op(8'h80, 8'h01);
        do_op(8'h7F, 8'hFF);
        do_op(8'h5A, 8'h5A);
        do_op(8'd3, 8'd1);
        for (int i = 0; i < 3; i++) begin
            av = W'($urandom);
            bv = W'($urandom);
            do_op(av, bv);
        end

        // start held high while operands change every cycle
        n_done = 0;
        start  = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (c > 0) @(negedge clk);
            exp_done = ((c % 10) == 9);
            check("held_done", done, exp_done);
            if (done === 1'b1) begin
                n_done++;
                if (sb.size() > 0) compare_result();
            end
            av = W'($urandom);
            bv = W'($urandom);
            a  = av;
            b  = bv;
            if ((c % 10) == 0) sb.push_back(model(av, bv));
        end
        @(negedge clk);
        start = 1'b0;
        check("held_done_count", n_done, 3);
        check("held_idle", busy, 0);

        // asynchronous reset in the middle of RUN
        start = 1'b1;
        a     = 8'h33;
        b     = 8'h11;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_diff", diff, 0);
        check("async_rst_flags", {borrow, ovf, zero, busy, done}, 0);
        start = 1'b1;
        a     = 8'hF0;
        b     = 8'h0F;
        @(negedge clk);
        check("rst_ignores_start", {busy, done}, 0);
        rst       = 1'b0;
        last_diff = '0;
        do_op(8'd9, 8'd4);
        check("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
